// File: rtl/pid_multichannel.sv
// Time-multiplexed PID controller: NUM_CH loops share one multiplier datapath.
// Optional derivative low-pass filter enabled by macro PID_DERIV_FILTER_EN.
module pid_multichannel #(
    parameter int NUM_CH                 = 4,
    parameter int CH_W                   = 2,
    parameter int INPUT_WIDTH            = 20,
    parameter int OUTPUT_WIDTH           = 16,
    parameter int PID_PARAM_WIDTH        = 16,
    parameter int PID_PARAM_FP_PRECISION = 8,
    parameter int MAX_OVF_SUM            = 4,
    parameter int DFILT_SHIFT            = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              cfg_we,
    input  logic [CH_W-1:0]                   cfg_ch,
    input  logic [1:0]                        cfg_sel,
    input  logic signed [PID_PARAM_WIDTH-1:0] cfg_data,
    input  logic                              int_clr,
    input  logic [CH_W-1:0]                   int_clr_ch,
    input  logic signed [OUTPUT_WIDTH-1:0]    out_min,
    input  logic signed [OUTPUT_WIDTH-1:0]    out_max,
    input  logic                              trig,
    input  logic [CH_W-1:0]                   trig_ch,
    input  logic signed [INPUT_WIDTH-1:0]     setpoint,
    input  logic signed [INPUT_WIDTH-1:0]     feedback,
    output logic                              busy,
    output logic signed [OUTPUT_WIDTH-1:0]    sig_out,
    output logic [CH_W-1:0]                   out_ch,
    output logic                              done
);
    localparam int IW   = INPUT_WIDTH;
    localparam int OW   = OUTPUT_WIDTH;
    localparam int PW   = PID_PARAM_WIDTH;
    localparam int DW   = (IW > OW) ? IW : OW;
    localparam int PADW = DW - IW;
    localparam int SW   = DW + MAX_OVF_SUM;
    localparam int DMW  = IW + 1;
    localparam int AW   = PW + SW + 2;

    typedef enum logic [2:0] {S_IDLE, S_ERR, S_MULT, S_SUM, S_SAT} state_t;
    state_t state, state_n;

    logic signed [PW-1:0]  kp [NUM_CH];
    logic signed [PW-1:0]  ki [NUM_CH];
    logic signed [PW-1:0]  kd [NUM_CH];
    logic signed [SW-1:0]  esum [NUM_CH];
    logic signed [IW-1:0]  prev_fb [NUM_CH];
    logic                  first [NUM_CH];
`ifdef PID_DERIV_FILTER_EN
    logic signed [DMW-1:0] dfilt [NUM_CH];
`endif

    logic [CH_W-1:0]       ch_q;
    logic signed [IW-1:0]  sp_q, fb_q;
    logic signed [PW-1:0]  kp_q, ki_q, kd_q;
    logic signed [DW-1:0]  err_q;
    logic signed [SW-1:0]  cand_q;
    logic signed [DMW-1:0] dm_q;
    logic signed [PW+DW-1:0]  pp_q;
    logic signed [PW+SW-1:0]  pi_q;
    logic signed [PW+DMW-1:0] pd_q;
    logic signed [AW-1:0]  acc_q;
    logic signed [OW-1:0]  res_q;
    logic [CH_W-1:0]       res_ch;
    logic                  pend;

    logic                  accept;
    logic signed [DW-1:0]  sp_a, fb_a, err_c;
    logic signed [DW:0]    diff;
    logic signed [SW:0]    sum_x;
    logic signed [SW-1:0]  cand_c;
    logic signed [DMW-1:0] d_c, dterm;
    logic signed [AW-1:0]  t;
    logic signed [OW-1:0]  r;
    logic                  lo_v, hi_v, commit;

    assign accept = trig && (32'(trig_ch) < NUM_CH);
    assign busy   = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:  if (accept) state_n = S_ERR;
            S_ERR:   state_n = S_MULT;
            S_MULT:  state_n = S_SUM;
            S_SUM:   state_n = S_SAT;
            S_SAT:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Inputs narrower than DW are MSB-aligned.
    always_comb begin
        sp_a   = DW'(sp_q) <<< PADW;
        fb_a   = DW'(fb_q) <<< PADW;
        diff   = (DW+1)'(sp_a) - (DW+1)'(fb_a);
        err_c  = (diff[DW] != diff[DW-1]) ?
                 {diff[DW], {(DW-1){~diff[DW]}}} : diff[DW-1:0];
        sum_x  = (SW+1)'(esum[ch_q]) + (SW+1)'(err_c);
        cand_c = (sum_x[SW] != sum_x[SW-1]) ?
                 {sum_x[SW], {(SW-1){~sum_x[SW]}}} : sum_x[SW-1:0];
        d_c    = first[ch_q] ?
                 DMW'(prev_fb[ch_q]) - DMW'(fb_q) : '0;
`ifdef PID_DERIV_FILTER_EN
        dterm  = dfilt[ch_q] + DMW'(((DMW+1)'(d_c)
                 - (DMW+1)'(dfilt[ch_q])) >>> DFILT_SHIFT);
`else
        dterm  = d_c;
`endif
    end

    // Min check first, then max: an inverted window yields out_max.
    always_comb begin
        lo_v   = acc_q < AW'(out_min);
        t      = lo_v ? AW'(out_min) : acc_q;
        hi_v   = t > AW'(out_max);
        r      = hi_v ? out_max : OW'(t);
        commit = !((hi_v && !err_q[DW-1] && (err_q != '0)) ||
                   (lo_v && !hi_v && err_q[DW-1]));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                kp[i] <= '0;
                ki[i] <= '0;
                kd[i] <= '0;
            end
        end else if (cfg_we) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cfg_ch == CH_W'(i)) begin
                    unique case (cfg_sel)
                        2'd0:    kp[i] <= cfg_data;
                        2'd1:    ki[i] <= cfg_data;
                        2'd2:    kd[i] <= cfg_data;
                        default: ;
                    endcase
                end
            end
        end
    end

    // Integrator clear is applied after the commit so it wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                esum[i]    <= '0;
                prev_fb[i] <= '0;
                first[i]   <= 1'b0;
`ifdef PID_DERIV_FILTER_EN
                dfilt[i]   <= '0;
`endif
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (state == S_SAT && ch_q == CH_W'(i)) begin
                    if (commit) esum[i] <= cand_q;
                    prev_fb[i] <= fb_q;
                    first[i]   <= 1'b1;
`ifdef PID_DERIV_FILTER_EN
                    dfilt[i]   <= dm_q;
`endif
                end
                if (int_clr && int_clr_ch == CH_W'(i)) begin
                    esum[i]  <= '0;
                    first[i] <= 1'b0;
`ifdef PID_DERIV_FILTER_EN
                    dfilt[i] <= '0;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ch_q   <= '0;
            sp_q   <= '0;
            fb_q   <= '0;
            kp_q   <= '0;
            ki_q   <= '0;
            kd_q   <= '0;
            err_q  <= '0;
            cand_q <= '0;
            dm_q   <= '0;
            pp_q   <= '0;
            pi_q   <= '0;
            pd_q   <= '0;
            acc_q  <= '0;
        end else begin
            if (state == S_IDLE && accept) begin
                ch_q <= trig_ch;
                sp_q <= setpoint;
                fb_q <= feedback;
                kp_q <= kp[trig_ch];
                ki_q <= ki[trig_ch];
                kd_q <= kd[trig_ch];
            end
            if (state == S_ERR) begin
                err_q  <= err_c;
                cand_q <= cand_c;
                dm_q   <= dterm;
            end
            if (state == S_MULT) begin
                pp_q <= (PW+DW)'(kp_q) * (PW+DW)'(err_q);
                pi_q <= (PW+SW)'(ki_q) * (PW+SW)'(cand_q);
                pd_q <= (PW+DMW)'(kd_q) * (PW+DMW)'(dm_q);
            end
            if (state == S_SUM)
                acc_q <= (AW'(pp_q) + AW'(pi_q) + AW'(pd_q))
                         >>> PID_PARAM_FP_PRECISION;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res_q   <= '0;
            res_ch  <= '0;
            pend    <= 1'b0;
            sig_out <= '0;
            out_ch  <= '0;
            done    <= 1'b0;
        end else begin
            pend <= (state == S_SAT);
            done <= pend;
            if (state == S_SAT) begin
                res_q  <= r;
                res_ch <= ch_q;
            end
            if (pend) begin
                sig_out <= res_q;
                out_ch  <= res_ch;
            end
        end
    end
endmodule

// File: tb/tb_pid_multichannel.sv
// Self-checking bench for pid_multichannel: directed table, hand sequences,
// and randomized traffic against an arithmetic reference model.
module tb_pid_multichannel;
    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               cfg_we = 1'b0;
    logic [1:0]         cfg_ch = '0;
    logic [1:0]         cfg_sel = '0;
    logic signed [15:0] cfg_data = '0;
    logic               int_clr = 1'b0;
    logic [1:0]         int_clr_ch = '0;
    logic signed [15:0] out_min = -16'sd32768;
    logic signed [15:0] out_max = 16'sd32767;
    logic               trig = 1'b0;
    logic [1:0]         trig_ch = '0;
    logic signed [19:0] setpoint = '0;
    logic signed [19:0] feedback = '0;
    logic               busy;
    logic signed [15:0] sig_out;
    logic [1:0]         out_ch;
    logic               done;

    always #5 clk = ~clk;

    pid_multichannel dut (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel),
        .cfg_data(cfg_data),
        .int_clr(int_clr), .int_clr_ch(int_clr_ch),
        .out_min(out_min), .out_max(out_max),
        .trig(trig), .trig_ch(trig_ch),
        .setpoint(setpoint), .feedback(feedback),
        .busy(busy), .sig_out(sig_out), .out_ch(out_ch), .done(done)
    );

    int nvec = 0;
    int nerr = 0;

    longint m_kp[4], m_ki[4], m_kd[4], m_es[4], m_pf[4], m_df[4];
    bit     m_first[4];
    longint omin = -32768;
    longint omax = 32767;

    task automatic chk(input string nm, input longint got, input longint exp);
        nvec++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    function automatic longint sat(input longint x, input int w);
        longint lim;
        lim = 64'sd1 <<< (w - 1);
        if (x > lim - 1) return lim - 1;
        if (x < -lim) return -lim;
        return x;
    endfunction

    task automatic model_clear_all();
        for (int i = 0; i < 4; i++) begin
            m_kp[i] = 0; m_ki[i] = 0; m_kd[i] = 0;
            m_es[i] = 0; m_pf[i] = 0; m_df[i] = 0;
            m_first[i] = 0;
        end
    endtask

    task automatic model_step(input int ch, input longint sp, input longint fb,
                              output longint res);
        longint err, dm, cand, acc;
        bit amax, amin;
        err = sat(sp - fb, 20);
        dm = m_first[ch] ? (m_pf[ch] - fb) : 0;
`ifdef PID_DERIV_FILTER_EN
        m_df[ch] = m_df[ch] + ((dm - m_df[ch]) >>> 2);
        dm = m_df[ch];
`endif
        cand = sat(m_es[ch] + err, 24);
        acc = (m_kp[ch] * err + m_ki[ch] * cand + m_kd[ch] * dm) >>> 8;
        res = acc; amax = 0; amin = 0;
        if (res < omin) begin res = omin; amin = 1; end
        if (res > omax) begin res = omax; amax = 1; amin = 0; end
        if (!((amax && err > 0) || (amin && err < 0))) m_es[ch] = cand;
        m_pf[ch] = fb;
        m_first[ch] = 1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_clear_all();
        @(negedge clk);
    endtask

    task automatic cfg(input int ch, input int sel, input longint d);
        cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_sel = 2'(sel);
        cfg_data = 16'(d);
        @(posedge clk);
        #1 cfg_we = 1'b0;
        if (sel == 0) m_kp[ch] = d;
        else if (sel == 1) m_ki[ch] = d;
        else if (sel == 2) m_kd[ch] = d;
        @(negedge clk);
    endtask

    task automatic clr(input int ch);
        int_clr = 1'b1; int_clr_ch = 2'(ch);
        @(posedge clk);
        #1 int_clr = 1'b0;
        m_es[ch] = 0; m_first[ch] = 0; m_df[ch] = 0;
        @(negedge clk);
    endtask

    // Issues one trig and waits (bounded) for done; lat=0 means timeout.
    task automatic apply(input int ch, input longint sp, input longint fb,
                         output int lat);
        out_min = 16'(omin); out_max = 16'(omax);
        trig = 1'b1; trig_ch = 2'(ch);
        setpoint = 20'(sp); feedback = 20'(fb);
        @(posedge clk);
        #1 trig = 1'b0;
        lat = 0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin lat = n; break; end
        end
    endtask

    typedef struct {
        int     ch;
        longint sp, fb, lo, hi, exp;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int     lat, dones, ch;
        longint mexp, got_out, sp, fb;

        tbl[0]  = '{0, 1000, 400, -32768, 32767, 600};
        tbl[1]  = '{1, 100, 0, -32768, 32767, 50};
        tbl[2]  = '{1, 100, 0, -32768, 32767, 100};
        tbl[3]  = '{1, 100, 0, -32768, 32767, 150};
        tbl[4]  = '{3, 0, 100, -32768, 32767, 0};
        tbl[5]  = '{3, 0, 80, -32768, 32767, 20};
        tbl[6]  = '{2, 500, 0, -32768, 200, 200};
        tbl[7]  = '{2, 500, 0, -32768, 200, 200};
        tbl[8]  = '{2, -50, 0, -32768, 200, -100};
        tbl[9]  = '{0, 0, 300, -100, 32767, -100};
        tbl[10] = '{0, 10, 0, 50, 20, 20};

        @(negedge clk);
        do_reset();
        chk("reset_sig_out", sig_out, 0);
        chk("reset_out_ch", out_ch, 0);
        chk("reset_done", done, 0);
        chk("reset_busy", busy, 0);

        cfg(0, 0, 256);
        cfg(1, 1, 128);
        cfg(2, 0, 256);
        cfg(2, 1, 256);
        cfg(3, 2, 256);

        foreach (tbl[i]) begin
            omin = tbl[i].lo; omax = tbl[i].hi;
            apply(tbl[i].ch, tbl[i].sp, tbl[i].fb, lat);
            model_step(tbl[i].ch, tbl[i].sp, tbl[i].fb, mexp);
            chk($sformatf("tbl%0d_latency", i), lat, 5);
            chk($sformatf("tbl%0d_sig_out", i), sig_out, tbl[i].exp);
            chk($sformatf("tbl%0d_out_ch", i), out_ch, tbl[i].ch);
        end
        omin = -32768; omax = 32767;

        // trig while busy is dropped; only ch0 result appears
        out_min = 16'(omin); out_max = 16'(omax);
        trig = 1'b1; trig_ch = 2'd0; setpoint = 20'sd7; feedback = 20'sd0;
        @(posedge clk);
        #1 trig = 1'b0;
        @(negedge clk);
        chk("busy_high", busy, 1);
        trig = 1'b1; trig_ch = 2'd1; setpoint = 20'sd100; feedback = 20'sd0;
        @(posedge clk);
        #1 trig = 1'b0;
        dones = 0; got_out = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                got_out = sig_out;
                chk("ignored_trig_ch", out_ch, 0);
            end
        end
        model_step(0, 7, 0, mexp);
        chk("ignored_trig_dones", dones, 1);
        chk("ignored_trig_out", got_out, mexp);

        // back-to-back interleave; ch1 integrator untouched by dropped trig
        for (int k = 0; k < 6; k++) begin
            ch = k % 2;
            sp = 100 + 37 * k; fb = 20 * k;
            apply(ch, sp, fb, lat);
            model_step(ch, sp, fb, mexp);
            chk("interleave_latency", lat, 5);
            chk("interleave_sig_out", sig_out, mexp);
            chk("interleave_out_ch", out_ch, ch);
        end

        // reset in MULT aborts the calculation
        trig = 1'b1; trig_ch = 2'd1; setpoint = 20'sd100; feedback = 20'sd0;
        @(posedge clk);
        #1 trig = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_sig_out", sig_out, 0);
        chk("abort_done", done, 0);
        reset = 1'b0;
        model_clear_all();
        dones = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("abort_no_done", dones, 0);

        // int_clr: next result has only err*ki integrator contribution
        cfg(1, 1, 128);
        apply(1, 100, 0, lat);
        model_step(1, 100, 0, mexp);
        chk("clr_pre1", sig_out, 50);
        apply(1, 100, 0, lat);
        model_step(1, 100, 0, mexp);
        chk("clr_pre2", sig_out, 100);
        clr(1);
        apply(1, 100, 0, lat);
        model_step(1, 100, 0, mexp);
        chk("clr_post", sig_out, 50);

        // randomized traffic against the model
        for (int i = 0; i < 4; i++) begin
            cfg(i, 0, longint'($urandom_range(0, 1023)) - 256);
            cfg(i, 1, longint'($urandom_range(0, 255)) - 64);
            cfg(i, 2, longint'($urandom_range(0, 511)) - 128);
        end
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 7) == 0)
                cfg($urandom_range(0, 3), $urandom_range(0, 3),
                    longint'($urandom_range(0, 2047)) - 1024);
            if ($urandom_range(0, 9) == 0)
                clr($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                omin = -32768; omax = 32767;
            end else begin
                omin = -longint'($urandom_range(0, 30000));
                omax = longint'($urandom_range(0, 30000));
            end
            if ($urandom_range(0, 1) == 0) begin
                sp = longint'($urandom_range(0, 4000)) - 2000;
                fb = longint'($urandom_range(0, 4000)) - 2000;
            end else begin
                sp = longint'($urandom_range(0, 1048575)) - 524288;
                fb = longint'($urandom_range(0, 1048575)) - 524288;
            end
            ch = $urandom_range(0, 3);
            apply(ch, sp, fb, lat);
            model_step(ch, sp, fb, mexp);
            chk("rand_latency", lat, 5);
            chk("rand_sig_out", sig_out, mexp);
            chk("rand_out_ch", out_ch, ch);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
